voice_allocator: RTL and testbench
==================================

// Module: voice_allocator
// PURPOSE
// - Polyphony scheduler: shares N_VOICES synth voices among N_KEYS requesters (keys/buttons).
// - Inputs are one-cycle press/release pulses from per-key debounce edge detectors.
// - Outputs per-voice gate, assigned key and retrigger pulse to the oscillator/envelope bank.
// - Voice stealing: when no voice is free, the oldest voice is stolen.
// PARAMETERS
// N_KEYS    8  number of key requesters
// N_VOICES  4  number of voices
// AGE_W     8  per-voice age counter width, saturating
// PORTS
// clk          in   1                  system clock
// rst          in   1                  reset, synchronous, active-high
// key_press    in   N_KEYS             one-cycle press pulse per key
// key_release  in   N_KEYS             one-cycle release pulse per key
// voice_gate   out  N_VOICES           1 = voice sounding
// voice_key    out  N_VOICES*KEY_W     key index driving voice v (bits v*KEY_W +: KEY_W)
// voice_trig   out  N_VOICES           one-cycle (re)start pulse per voice
// steal        out  1                  one-cycle pulse: this cycle's allocation stole a voice
// busy         out  1                  any press pending, not yet allocated
// BEHAVIOUR
// - KEY_W = $clog2(N_KEYS); all outputs registered.
// - Reset: voice_gate=0, voice_key=0, voice_trig=0, steal=0, busy=0, ages=0, pending=0, rr_ptr=0.
// - Pending: key_press[k] at edge t sets pending[k]. key_release[k] at edge t clears pending[k].
// - Press and release of the same key at the same edge: press wins (pending set). The release
//   still frees any voice currently holding k.
// - Service: at most one pending key per cycle. Round-robin from rr_ptr picks key k.
//   pending[k] is cleared and rr_ptr becomes k+1 (mod N_KEYS).
//   Latency: press at edge t -> voice_gate/voice_trig visible after edge t+1.
// - Allocation of k, evaluated in priority order:
//   1. k already gated on voice v: retrigger. trig[v]=1, age[v]=0, key unchanged.
//   2. Else lowest-index voice with gate=0: gate=1, key=k, trig=1, age=0.
//   3. Else steal the voice with max age (tie -> lowest index): key=k, trig=1, age=0,
//      gate stays 1, steal=1.
// - Ages: each cycle a voice is allocated, every other gated voice increments its age,
//   saturating at 2^AGE_W-1. Ungated voices hold age 0.
// - Release: key_release[k] clears gate on every voice with gate=1 and key==k, same edge.
//   voice_key holds its last value.
// - Release and allocation on the same voice at the same edge: allocation wins (gate=1, trig=1).
// - voice_trig and steal are 1 for exactly the cycle following the allocating edge.
// - busy = |pending, registered.
// - Presses arriving while pending[k] is already set merge into one request.
// - rst mid-operation: all state returns to reset values at the next edge. Pending requests
//   are dropped.
// STRUCTURE
// - synth_pkg holds:
//   - constants N_KEYS_DEF, N_VOICES_DEF
//   - typedef voice_state_t {logic gate; logic [KEY_W-1:0] key; logic [AGE_W-1:0] age;}
// - Sub-module rr_arbiter #(N) (req, ptr -> gnt one-hot, gnt_valid): combinational pick,
//   with rr_ptr registered in voice_allocator.
// - Voice search (match / free / oldest) is combinational priority logic in voice_allocator.
// TESTING
// - Reset: assert rst 2 cycles mid-activity -> all outputs 0 next cycle; pending press not serviced.
// - Single note: press k=3 at edge t -> gate[0]=1, key[0]=3, trig[0]=1 for 1 cycle after t+1.
//   Release k=3 -> gate[0]=0.
// - Simultaneous presses k=1,5,6 at same edge -> allocated on consecutive cycles to voices 0,1,2
//   in round-robin order 1,5,6. busy=1 for those cycles.
// - Stealing: press 0,1,2,3 (fills 4 voices), then press 7 -> voice 0 (oldest) gets key 7,
//   trig[0]=1, steal=1, gates all stay 1.
// - Retrigger and age: repress held key 2 on voice 2 -> trig[2]=1, no new voice, age[2]=0.
//   Next steal then skips voice 2.
// - Same-edge press and release of key 4 while held on voice 1 -> voice 1 gate drops, then
//   key 4 is reallocated to voice 1 (lowest free) with trig.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants and per-voice state record for the polyphony scheduler.
package synth_pkg;
  localparam int N_KEYS_DEF   = 8;
  localparam int N_VOICES_DEF = 4;
  localparam int AGE_W        = 8;
  localparam int KEY_W        = $clog2(N_KEYS_DEF);

  typedef struct packed {
    logic             gate;
    logic [KEY_W-1:0] key;
    logic [AGE_W-1:0] age;
  } voice_state_t;
endpackage

// File: rtl/voice_allocator_if.sv
// Key-pulse inputs and voice-bank outputs of the voice allocator.
interface voice_allocator_if
  import synth_pkg::*;
#(
  parameter int N_KEYS   = N_KEYS_DEF,
  parameter int N_VOICES = N_VOICES_DEF,
  parameter int KW       = $clog2(N_KEYS)
);
  // No back-pressure: key_press/key_release are single-cycle pulses that are always
  // accepted; voice_trig and steal are single-cycle pulses the voice bank must take.
  logic [N_KEYS-1:0]      key_press;
  logic [N_KEYS-1:0]      key_release;
  logic [N_VOICES-1:0]    voice_gate;
  logic [N_VOICES*KW-1:0] voice_key;
  logic [N_VOICES-1:0]    voice_trig;
  logic                   steal;
  logic                   busy;

  modport master (
    output key_press, key_release,
    input  voice_gate, voice_key, voice_trig, steal, busy
  );

  modport slave (
    input  key_press, key_release,
    output voice_gate, voice_key, voice_trig, steal, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 8,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid
);
  logic [PW-1:0] idx;

  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: one pending key per cycle is placed on a matching, free or oldest voice.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int N_VOICES = N_VOICES_DEF
) (
  input  logic clk,
  input  logic rst,
  voice_allocator_if.slave bus
);
  localparam int N_KEYS = N_KEYS_DEF;
  localparam int VW     = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

  logic [N_KEYS-1:0]   pending;
  logic [KEY_W-1:0]    rr_ptr;
  voice_state_t        voices [N_VOICES];
  logic [N_VOICES-1:0] trig;
  logic                steal_q;

  logic [N_KEYS-1:0]   gnt;
  logic                gnt_valid;
  logic [KEY_W-1:0]    gnt_key;

  rr_arbiter #(.N(N_KEYS)) u_arb (
    .req       (pending),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    gnt_key = '0;
    for (int k = 0; k < N_KEYS; k++)
      if (gnt[k]) gnt_key = KEY_W'(k);
  end

  // Voice search: match beats free beats oldest; strict '>' keeps the lowest index on ties.
  logic             match_hit, free_hit, do_steal;
  logic [VW-1:0]    match_v, free_v, old_v, tgt_v;
  logic [AGE_W-1:0] old_age;

  always_comb begin
    match_hit = 1'b0;
    free_hit  = 1'b0;
    match_v   = '0;
    free_v    = '0;
    old_v     = '0;
    old_age   = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      if (!match_hit && voices[v].gate && voices[v].key == gnt_key) begin
        match_hit = 1'b1;
        match_v   = VW'(v);
      end
      if (!free_hit && !voices[v].gate) begin
        free_hit = 1'b1;
        free_v   = VW'(v);
      end
      if (voices[v].age > old_age) begin
        old_age = voices[v].age;
        old_v   = VW'(v);
      end
    end
    tgt_v    = match_hit ? match_v : (free_hit ? free_v : old_v);
    do_steal = gnt_valid && !match_hit && !free_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      rr_ptr  <= '0;
      trig    <= '0;
      steal_q <= 1'b0;
      for (int v = 0; v < N_VOICES; v++) voices[v] <= '0;
    end else begin
      // A press always (re)arms the request, even against a same-edge release.
      pending <= bus.key_press | (pending & ~bus.key_release & ~gnt);
      if (gnt_valid)
        rr_ptr <= (gnt_key == KEY_W'(N_KEYS - 1)) ? '0 : gnt_key + 1'b1;
      steal_q <= do_steal;
      for (int v = 0; v < N_VOICES; v++) begin
        trig[v] <= 1'b0;
        if (gnt_valid && tgt_v == VW'(v)) begin
          voices[v].gate <= 1'b1;
          voices[v].key  <= gnt_key;
          voices[v].age  <= '0;
          trig[v]        <= 1'b1;
        end else if (voices[v].gate && bus.key_release[voices[v].key]) begin
          voices[v].gate <= 1'b0;
          voices[v].age  <= '0;
        end else if (gnt_valid && voices[v].gate && voices[v].age != '1) begin
          voices[v].age <= voices[v].age + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.voice_gate = '0;
    bus.voice_key  = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      bus.voice_gate[v]                  = voices[v].gate;
      bus.voice_key[v*KEY_W +: KEY_W]    = voices[v].key;
    end
  end

  assign bus.voice_trig = trig;
  assign bus.steal      = steal_q;
  assign bus.busy       = |pending;
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation order, stealing, retrigger, release and reset.
module tb_voice_allocator;
  import synth_pkg::*;

  logic clk = 1'b0;
  logic rst;

  voice_allocator_if bus ();

  voice_allocator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [KEY_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [KEY_W-1:0] vkey(input int v);
    return bus.voice_key[v*KEY_W +: KEY_W];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] p, input logic [7:0] r);
    bus.key_press   = p;
    bus.key_release = r;
    step();
    bus.key_press   = '0;
    bus.key_release = '0;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] gate, input logic [3:0] trg,
                            input logic stl, input logic bsy);
    check({tag, ".gate"},  32'(bus.voice_gate), 32'(gate));
    check({tag, ".trig"},  32'(bus.voice_trig), 32'(trg));
    check({tag, ".steal"}, 32'(bus.steal),      32'(stl));
    check({tag, ".busy"},  32'(bus.busy),       32'(bsy));
  endtask

  initial begin
    rst             = 1'b1;
    bus.key_press   = '0;
    bus.key_release = '0;
    repeat (2) step();
    rst = 1'b0;
    check_outs("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
    check("reset.key", 32'(bus.voice_key), 32'h0);

    // Three simultaneous presses, served 1,5,6 onto voices 0,1,2.
    drive(8'b0110_0010, 8'h00);
    check_outs("multi.pend", 4'b0000, 4'b0000, 1'b0, 1'b1);
    exp_q = '{3'd1, 3'd5, 3'd6};
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs($sformatf("multi.a%0d", i), 4'((1 << (i + 1)) - 1), 4'(1 << i), 1'b0,
                 (i < 2) ? 1'b1 : 1'b0);
      check($sformatf("multi.key%0d", i), 32'(vkey(i)), 32'(exp_q.pop_front()));
    end
    step();
    check_outs("multi.idle", 4'b0111, 4'b0000, 1'b0, 1'b0);
    drive(8'h00, 8'b0110_0010);
    check_outs("multi.rel", 4'b0000, 4'b0000, 1'b0, 1'b0);
    check("multi.keyhold", 32'(vkey(1)), 32'd5);

    // Single note on key 3.
    drive(8'h08, 8'h00);
    check_outs("single.pend", 4'b0000, 4'b0000, 1'b0, 1'b1);
    step();
    check_outs("single.alloc", 4'b0001, 4'b0001, 1'b0, 1'b0);
    check("single.key", 32'(vkey(0)), 32'd3);
    step();
    check_outs("single.hold", 4'b0001, 4'b0000, 1'b0, 1'b0);
    drive(8'h00, 8'h08);
    check_outs("single.rel", 4'b0000, 4'b0000, 1'b0, 1'b0);
    check("single.keyhold", 32'(vkey(0)), 32'd3);

    // Fill all voices with keys 0..3, then steal the oldest.
    drive(8'h0F, 8'h00);
    repeat (4) step();
    check_outs("fill", 4'b1111, 4'b1000, 1'b0, 1'b0);
    for (int v = 0; v < 4; v++) check($sformatf("fill.key%0d", v), 32'(vkey(v)), 32'(v));
    drive(8'h80, 8'h00);
    step();
    check_outs("steal7", 4'b1111, 4'b0001, 1'b1, 1'b0);
    check("steal7.key", 32'(vkey(0)), 32'd7);
    step();
    check_outs("steal7.after", 4'b1111, 4'b0000, 1'b0, 1'b0);
    drive(8'h10, 8'h00);
    step();
    check_outs("steal4", 4'b1111, 4'b0010, 1'b1, 1'b0);
    check("steal4.key", 32'(vkey(1)), 32'd4);

    // Retrigger held key 2; the next steal must pass over voice 2.
    drive(8'h04, 8'h00);
    step();
    check_outs("retrig", 4'b1111, 4'b0100, 1'b0, 1'b0);
    check("retrig.key2", 32'(vkey(2)), 32'd2);
    check("retrig.key0", 32'(vkey(0)), 32'd7);
    drive(8'h20, 8'h00);
    step();
    check_outs("steal5", 4'b1111, 4'b1000, 1'b1, 1'b0);
    check("steal5.key3", 32'(vkey(3)), 32'd5);
    check("steal5.key2", 32'(vkey(2)), 32'd2);

    // Same-edge press and release of key 4 held on voice 1.
    drive(8'h10, 8'h10);
    check_outs("pr.rel", 4'b1101, 4'b0000, 1'b0, 1'b1);
    check("pr.keyhold", 32'(vkey(1)), 32'd4);
    step();
    check_outs("pr.realloc", 4'b1111, 4'b0010, 1'b0, 1'b0);
    check("pr.key", 32'(vkey(1)), 32'd4);

    // Reset mid-activity drops the pending press.
    drive(8'h40, 8'h00);
    check("mid.busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step();
    check_outs("mid.rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
    check("mid.key", 32'(bus.voice_key), 32'h0);
    step();
    rst = 1'b0;
    step();
    check_outs("mid.after", 4'b0000, 4'b0000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
